// File: rtl/instr_fetch_align.sv
// instr_fetch_align: imem reader that realigns words into 16/32-bit instructions for the decoder.
// Optional FETCH_MISALIGN_EN adds fetch_misalign and an error state for odd redirect targets.
module instr_fetch_align #(
   parameter int          ADDR_WIDTH = 11,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc,
   output logic                  instr_is_comp
`ifdef FETCH_MISALIGN_EN
   ,
   output logic                  fetch_misalign
`endif
);
   logic [29:0] fetch_wp;
   logic [63:0] hw_q, hw_d, keep_mask, app_data;
   logic [2:0]  count, base, proj;
   logic [1:0]  cons, n_app;
   logic        req_inflight, skip_hi, err, issue, bad_pc;
`ifdef FETCH_MISALIGN_EN
   assign bad_pc         = redirect_pc[0];
   assign fetch_misalign = err;
`else
   assign bad_pc = 1'b0;
`endif
   assign imem_addr     = fetch_wp[ADDR_WIDTH-1:0];
   assign instr_is_comp = (count != 3'd0) && (hw_q[1:0] != 2'b11);
   assign instr_valid   = instr_is_comp || (count >= 3'd2);
   assign instr         = instr_is_comp ? {16'h0, hw_q[15:0]} : hw_q[31:0];
   always_comb begin
      cons      = (instr_valid && instr_ready) ? (instr_is_comp ? 2'd1 : 2'd2) : 2'd0;
      base      = count - {1'b0, cons};
      proj      = base + (req_inflight ? 3'd2 : 3'd0);
      issue     = !redirect_valid && !err && (proj <= 3'd2);
      n_app     = req_inflight ? (skip_hi ? 2'd1 : 2'd2) : 2'd0;
      app_data  = {32'h0, skip_hi ? {16'h0, imem_rdata[31:16]} : imem_rdata};
      keep_mask = (64'h1 << {base, 4'b0}) - 64'h1;
      // survivors shift toward hw0; the new word lands right after them
      hw_d      = ((hw_q >> {cons, 4'b0}) & keep_mask) | (req_inflight ? (app_data << {base, 4'b0}) : 64'h0);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_wp     <= RESET_PC[31:2];
         hw_q         <= '0;
         count        <= '0;
         req_inflight <= 1'b0;
         skip_hi      <= 1'b0;
         err          <= 1'b0;
         instr_pc     <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_wp     <= redirect_pc[31:2];
         count        <= '0;
         req_inflight <= 1'b0;
         skip_hi      <= redirect_pc[1];
         err          <= bad_pc;
         instr_pc     <= {redirect_pc[31:1], redirect_pc[0] & bad_pc};
      end else begin
         hw_q         <= hw_d;
         count        <= base + {1'b0, n_app};
         req_inflight <= issue;
         if (issue) fetch_wp <= fetch_wp + 30'd1;
         if (req_inflight) skip_hi <= 1'b0;
         instr_pc     <= instr_pc + {29'h0, cons, 1'b0};
      end
   end
endmodule

// File: tb/tb_instr_fetch_align.sv
// tb_instr_fetch_align: directed checks of fetch/realign/handshake/redirect behaviour.
module tb_instr_fetch_align;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [10:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr, instr_pc;
   logic        instr_is_comp;
`ifdef FETCH_MISALIGN_EN
   logic        fetch_misalign;
`endif
   logic [31:0] mem [0:2047];
   int          total = 0;
   int          passed = 0;

   instr_fetch_align dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .instr_is_comp(instr_is_comp)
`ifdef FETCH_MISALIGN_EN
      , .fetch_misalign(fetch_misalign)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s got %h expected %h", tag, obs, exp);
   endtask

   task automatic restart();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      // plain 32-bit stream
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0010_0093;
      tick();
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_comp", instr_is_comp, 0);
      chk("rst_addr", imem_addr, 0);
      restart();
      chk("c0_valid", instr_valid, 0);
      tick();
      chk("c1_valid", instr_valid, 0);
      tick();
      chk("t1_valid", instr_valid, 1);
      chk("t1_instr0", instr, 32'h0000_0013);
      chk("t1_pc0", instr_pc, 0);
      chk("t1_comp0", instr_is_comp, 0);
      tick();
      chk("t1_instr1", instr, 32'h0010_0093);
      chk("t1_pc1", instr_pc, 4);
      chk("t1_comp1", instr_is_comp, 0);
      // two compressed in one word
      mem[0] = 32'h0085_4501;
      mem[1] = 32'h0000_0013;
      restart();
      tick();
      tick();
      chk("t2_instr0", instr, 32'h0000_4501);
      chk("t2_pc0", instr_pc, 0);
      chk("t2_comp0", instr_is_comp, 1);
      tick();
      chk("t2_instr1", instr, 32'h0000_0085);
      chk("t2_pc1", instr_pc, 2);
      chk("t2_comp1", instr_is_comp, 1);
      // 32-bit instruction straddling a word boundary
      mem[0] = 32'h0013_4501;
      mem[1] = 32'h4501_0000;
      restart();
      tick();
      tick();
      chk("t3_instr0", instr, 32'h0000_4501);
      chk("t3_pc0", instr_pc, 0);
      tick();
      chk("t3_instr1", instr, 32'h0000_0013);
      chk("t3_pc1", instr_pc, 2);
      chk("t3_comp1", instr_is_comp, 0);
      tick();
      chk("t3_instr2", instr, 32'h0000_4501);
      chk("t3_pc2", instr_pc, 6);
      chk("t3_comp2", instr_is_comp, 1);
      // stall for 10 cycles, then drain in order
      for (int i = 0; i < 8; i++) mem[i] = 32'h13 | (i << 7);
      instr_ready = 1'b0;
      restart();
      tick();
      for (int i = 2; i < 12; i++) begin
         tick();
         chk("stall_valid", instr_valid, 1);
         chk("stall_instr", instr, 32'h13);
         chk("stall_pc", instr_pc, 0);
         chk("stall_addr", imem_addr, 2);
      end
      instr_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk("drain_valid", instr_valid, 1);
         chk("drain_instr", instr, 32'h13 | (j << 7));
         chk("drain_pc", instr_pc, 4 * j);
         tick();
      end
      // redirect to a halfword in the upper half of word 0x10
      mem[16] = 32'h4501_0000;
      mem[17] = 32'h0000_0013;
      redirect_valid = 1'b1;
      redirect_pc = 32'h42;
      tick();
      redirect_valid = 1'b0;
      chk("rd_valid1", instr_valid, 0);
      chk("rd_pc1", instr_pc, 32'h42);
      chk("rd_addr1", imem_addr, 11'h10);
      tick();
      chk("rd_valid2", instr_valid, 0);
      tick();
      chk("rd_valid3", instr_valid, 1);
      chk("rd_instr3", instr, 32'h4501);
      chk("rd_pc3", instr_pc, 32'h42);
      chk("rd_comp3", instr_is_comp, 1);
      tick();
      chk("rd_instr4", instr, 32'h13);
      chk("rd_pc4", instr_pc, 32'h44);
      chk("rd_comp4", instr_is_comp, 0);
      // address wrap at the top of imem
      mem[2047] = 32'h0000_0093;
      redirect_valid = 1'b1;
      redirect_pc = 32'h1FFC;
      tick();
      redirect_valid = 1'b0;
      chk("wr_addr1", imem_addr, 11'h7FF);
      tick();
      chk("wr_addr2", imem_addr, 11'h000);
      tick();
      chk("wr_instr3", instr, 32'h93);
      chk("wr_pc3", instr_pc, 32'h1FFC);
      tick();
      chk("wr_instr4", instr, 32'h13);
      chk("wr_pc4", instr_pc, 32'h2000);
      // asynchronous reset mid-stream
      #3;
      reset = 1'b0;
      #1;
      chk("ar_valid", instr_valid, 0);
      chk("ar_pc", instr_pc, 0);
      chk("ar_instr", instr, 0);
      chk("ar_addr", imem_addr, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_c1_valid", instr_valid, 0);
      tick();
      chk("ar_c2_instr", instr, 32'h13);
      chk("ar_c2_pc", instr_pc, 0);
`ifdef FETCH_MISALIGN_EN
      chk("mis_rst", fetch_misalign, 0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h41;
      tick();
      redirect_valid = 1'b0;
      chk("mis_flag1", fetch_misalign, 1);
      chk("mis_valid1", instr_valid, 0);
      tick();
      tick();
      tick();
      chk("mis_flag4", fetch_misalign, 1);
      chk("mis_valid4", instr_valid, 0);
      chk("mis_addr4", imem_addr, 11'h10);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      chk("mis_clear", fetch_misalign, 0);
      tick();
      tick();
      chk("mis_valid_resume", instr_valid, 1);
      chk("mis_instr_resume", instr, 0);
      chk("mis_pc_resume", instr_pc, 32'h40);
      chk("mis_comp_resume", instr_is_comp, 1);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
